// File: rtl/commit_ctrl_if.sv
// Commit stage handshake bundle between the ROB head and commit_ctrl.
// The master side drives the ROB head and store_ack; the slave side is the controller.
interface commit_ctrl_if #(
  parameter int ENTRY_W = 4
);
  logic               head_valid;
  logic               head_ready;
  logic [ENTRY_W-1:0] head_entry;
  logic [1:0]         head_type;
  logic [5:0]         head_rd;
  logic [31:0]        head_result;
  logic               head_mispredict;
  logic [31:0]        head_target_pc;
  logic               store_ack;
  logic               head_pop;
  logic               commit_sgn;
  logic [ENTRY_W-1:0] rob_entry;
  logic [5:0]         rob_des;
  logic [31:0]        rob_result;
  logic               store_req;
  logic [ENTRY_W-1:0] store_entry;
  logic               rollback;
  logic [31:0]        rollback_pc;
  logic [31:0]        commit_count;

  modport master (
    output head_valid, head_ready, head_entry,
    output head_type, head_rd, head_result,
    output head_mispredict, head_target_pc,
    output store_ack,
    input  head_pop, commit_sgn, rob_entry,
    input  rob_des, rob_result, store_req,
    input  store_entry, rollback, rollback_pc,
    input  commit_count
  );

  modport slave (
    input  head_valid, head_ready, head_entry,
    input  head_type, head_rd, head_result,
    input  head_mispredict, head_target_pc,
    input  store_ack,
    output head_pop, commit_sgn, rob_entry,
    output rob_des, rob_result, store_req,
    output store_entry, rollback, rollback_pc,
    output commit_count
  );
endinterface

// File: rtl/commit_ctrl.sv
// In-order commit controller: retires the ROB head, sequences stores,
// and raises a rollback pulse plus dead cycles on a mispredicted branch.
module commit_ctrl #(
  parameter int         ENTRY_W   = 4,
  parameter int         FLUSH_CYC = 2,
  parameter logic [5:0] REG_NULL  = 6'd32
) (
  input logic         clk,
  input logic         rst,
  input logic         rdy,
  commit_ctrl_if.slave cif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC);

  state_t state_q;
  state_t state_d;

  logic [3:0]         flush_q;
  logic               commit_q;
  logic [ENTRY_W-1:0] entry_q;
  logic [5:0]         des_q;
  logic [31:0]        result_q;
  logic               sreq_q;
  logic [ENTRY_W-1:0] sentry_q;
  logic               rb_q;
  logic [31:0]        rb_pc_q;
  logic [31:0]        count_q;

  logic head_ok;
  logic is_store;
  logic mispred;
  logic has_rd;
  logic retire;
  logic store_go;
  logic store_done;

  // Reserved type 11 falls through as an ordinary ALU/load retire.
  assign head_ok  = rdy & cif.head_valid & cif.head_ready;
  assign is_store = (cif.head_type == 2'b01);
  assign mispred  = (cif.head_type == 2'b10) & cif.head_mispredict;
  assign has_rd   = (cif.head_rd != 6'd0) && (cif.head_rd != REG_NULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (retire && mispred) begin
          state_d = FLUSH;
        end else if (store_go) begin
          state_d = STORE_WAIT;
        end
      end
      STORE_WAIT: begin
        if (store_done) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (flush_q <= 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    retire     = 1'b0;
    store_go   = 1'b0;
    store_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        retire   = head_ok & ~is_store;
        store_go = head_ok & is_store;
      end
      STORE_WAIT: store_done = rdy & cif.store_ack;
      default: ;
    endcase
    cif.head_pop = retire | store_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q  <= '0;
      commit_q <= 1'b0;
      entry_q  <= '0;
      des_q    <= '0;
      result_q <= '0;
      sreq_q   <= 1'b0;
      sentry_q <= '0;
      rb_q     <= 1'b0;
      rb_pc_q  <= '0;
      count_q  <= '0;
    end else if (rdy) begin
      commit_q <= 1'b0;
      rb_q     <= 1'b0;
      if (retire) begin
        commit_q <= has_rd;
        entry_q  <= cif.head_entry;
        des_q    <= cif.head_rd;
        result_q <= cif.head_result;
        count_q  <= count_q + 32'd1;
        if (mispred) begin
          rb_q    <= 1'b1;
          rb_pc_q <= cif.head_target_pc;
          flush_q <= FLUSH_INIT;
        end
      end
      if (store_go) begin
        sreq_q   <= 1'b1;
        sentry_q <= cif.head_entry;
      end
      if (store_done) begin
        sreq_q  <= 1'b0;
        count_q <= count_q + 32'd1;
      end
      if (state_q == FLUSH && flush_q != 4'd0) begin
        flush_q <= flush_q - 4'd1;
      end
    end
  end

  assign cif.commit_sgn   = commit_q;
  assign cif.rob_entry    = entry_q;
  assign cif.rob_des      = des_q;
  assign cif.rob_result   = result_q;
  assign cif.store_req    = sreq_q;
  assign cif.store_entry  = sentry_q;
  assign cif.rollback     = rb_q;
  assign cif.rollback_pc  = rb_pc_q;
  assign cif.commit_count = count_q;

endmodule
